// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared types and constants for the DDS key-driven
//                configuration controller: waveform and FSM state enums,
//                the frequency tuning-word table (50 MHz clock, 32-bit
//                accumulator) and the 90-degree phase step.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    SAW      = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } ctrl_state_t;

  localparam int TABLE_W = 32;
  localparam int TABLE_N = 8;

  // Tuning words for 1, 2, 5, 10, 20, 50, 100, 200 kHz at 50 MHz.
  localparam logic [TABLE_W-1:0] FREQ_TABLE [TABLE_N] = '{
    32'd85899,   32'd171799,  32'd429497,  32'd858993,
    32'd1717987, 32'd4294967, 32'd8589935, 32'd17179869
  };

  // Quarter of the 12-bit phase circle (+90 degrees).
  localparam int PHASE_STEP = 1024;

  function automatic logic [TABLE_W-1:0] freq_lookup(input int idx);
    return FREQ_TABLE[idx % TABLE_N];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer, stability counter and press-pulse
//                generator for one active-low push key.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                key_n_i        - raw key level, active low, asynchronous
//                press_o        - one-cycle pulse on debounced 1->0 edge
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q, prev_q;
  logic             deb_q, deb_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced level is steady and differs from
  // the debounced level; any toggle or a return to the old level restarts it.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if ((sync2_q != prev_q) || (sync2_q == deb_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= deb_q & ~deb_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/dds_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_ctrl
//  Description : Key-driven DDS configuration controller. Debounced key
//                presses step staged waveform / frequency index / phase;
//                staged values are applied together only after acc_wrap so
//                changes land on a phase-wrap boundary.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                key0_in/key1_in/key2_in - wave / freq / phase step keys
//                acc_wrap              - accumulator rollover pulse
//                freq_word, phase_word, wave_sel - applied configuration
//                cfg_valid             - pulse when applied outputs change
//                cfg_pending           - staged settings await acc_wrap
//  Option      : DDS_CTRL_AMP_EN adds key3_in and amp_shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int FW_W       = 32,
  parameter int PW_W       = 12,
  parameter int N_FREQ     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key0_in,
  input  logic            key1_in,
  input  logic            key2_in,
`ifdef DDS_CTRL_AMP_EN
  input  logic            key3_in,
  output logic [1:0]      amp_shift,
`endif
  input  logic            acc_wrap,
  output logic [FW_W-1:0] freq_word,
  output logic [PW_W-1:0] phase_word,
  output logic [1:0]      wave_sel,
  output logic            cfg_valid,
  output logic            cfg_pending
);

`ifdef DDS_CTRL_AMP_EN
  localparam int N_KEYS = 4;
`else
  localparam int N_KEYS = 3;
`endif
  localparam int FIDX_W = (N_FREQ > 1) ? $clog2(N_FREQ) : 1;
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(N_FREQ - 1);
  localparam logic [PW_W-1:0]   PH_INC    = PW_W'(PHASE_STEP);
  localparam logic [FW_W-1:0]   FREQ_RST  = FW_W'(FREQ_TABLE[0]);

  logic [N_KEYS-1:0] keys_n;
  logic [N_KEYS-1:0] press;
  logic              any_evt;

`ifdef DDS_CTRL_AMP_EN
  assign keys_n = {key3_in, key2_in, key1_in, key0_in};
`else
  assign keys_n = {key2_in, key1_in, key0_in};
`endif

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n_i (keys_n[k]),
      .press_o (press[k])
    );
  end

  assign any_evt = |press;

  // ---------------- FSM ----------------
  ctrl_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_evt) state_d = PEND;
      PEND:    if (acc_wrap) state_d = APPLY;
      // A press landing in the apply cycle is staged and must wait again.
      APPLY:   state_d = any_evt ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- staging ----------------
  wave_t             stg_wave_q, stg_wave_d;
  logic [FIDX_W-1:0] stg_fidx_q, stg_fidx_d;
  logic [PW_W-1:0]   stg_phase_q, stg_phase_d;

  always_comb begin
    stg_wave_d  = stg_wave_q;
    stg_fidx_d  = stg_fidx_q;
    stg_phase_d = stg_phase_q;
    if (press[0]) stg_wave_d  = wave_t'(stg_wave_q + 2'd1);
    if (press[1]) stg_fidx_d  = (stg_fidx_q == FIDX_LAST) ? '0 : stg_fidx_q + 1'b1;
    if (press[2]) stg_phase_d = stg_phase_q + PH_INC;
  end

  // ---------------- applied outputs ----------------
  logic [FW_W-1:0] freq_q, freq_d;
  logic [PW_W-1:0] phase_q, phase_d;
  logic [1:0]      wave_q, wave_d;
  logic            valid_q, valid_d;

  always_comb begin
    freq_d  = freq_q;
    phase_d = phase_q;
    wave_d  = wave_q;
    valid_d = 1'b0;
    if (state_q == APPLY) begin
      freq_d  = FW_W'(freq_lookup(int'(stg_fidx_q)));
      phase_d = stg_phase_q;
      wave_d  = stg_wave_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_wave_q  <= SINE;
      stg_fidx_q  <= '0;
      stg_phase_q <= '0;
      freq_q      <= FREQ_RST;
      phase_q     <= '0;
      wave_q      <= 2'd0;
      valid_q     <= 1'b0;
    end else begin
      stg_wave_q  <= stg_wave_d;
      stg_fidx_q  <= stg_fidx_d;
      stg_phase_q <= stg_phase_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      wave_q      <= wave_d;
      valid_q     <= valid_d;
    end
  end

`ifdef DDS_CTRL_AMP_EN
  logic [1:0] stg_amp_q, stg_amp_d;
  logic [1:0] amp_q, amp_d;

  always_comb begin
    stg_amp_d = stg_amp_q;
    amp_d     = amp_q;
    if (press[3]) stg_amp_d = stg_amp_q + 2'd1;
    if (state_q == APPLY) amp_d = stg_amp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_amp_q <= 2'd0;
      amp_q     <= 2'd0;
    end else begin
      stg_amp_q <= stg_amp_d;
      amp_q     <= amp_d;
    end
  end

  assign amp_shift = amp_q;
`endif

  assign freq_word   = freq_q;
  assign phase_word  = phase_q;
  assign wave_sel    = wave_q;
  assign cfg_valid   = valid_q;
  assign cfg_pending = (state_q == PEND);

endmodule
`default_nettype wire

// File: tb/tb_dds_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_ctrl
//  Description : Self-checking bench for dds_ctrl (DEB_CYCLES = 16).
//                A reference model of the staged settings pushes expected
//                configurations into a queue; every cfg_valid pulse is
//                captured and compared in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_ctrl;

  typedef struct packed {
    logic [31:0] f;
    logic [11:0] p;
    logic [1:0]  w;
  } cfg_t;

  typedef struct {
    logic [2:0]  mask;
    logic [1:0]  wave;
    logic [31:0] freq;
    logic [11:0] phase;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key0_in = 1'b1, key1_in = 1'b1, key2_in = 1'b1;
  logic        acc_wrap = 1'b0;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [1:0]  wave_sel;
  logic        cfg_valid, cfg_pending;
`ifdef DDS_CTRL_AMP_EN
  logic        key3_in = 1'b1;
  logic [1:0]  amp_shift;
`endif

  always #10 clk = ~clk;

  dds_ctrl #(.DEB_CYCLES(16), .FW_W(32), .PW_W(12), .N_FREQ(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key0_in     (key0_in),
    .key1_in     (key1_in),
    .key2_in     (key2_in),
`ifdef DDS_CTRL_AMP_EN
    .key3_in     (key3_in),
    .amp_shift   (amp_shift),
`endif
    .acc_wrap    (acc_wrap),
    .freq_word   (freq_word),
    .phase_word  (phase_word),
    .wave_sel    (wave_sel),
    .cfg_valid   (cfg_valid),
    .cfg_pending (cfg_pending)
  );

  // Capture every applied configuration.
  cfg_t obs [256];
  int   obs_wr = 0;
  always @(negedge clk) begin
    if (cfg_valid) begin
      obs[obs_wr % 256] <= '{f: freq_word, p: phase_word, w: wave_sel};
      obs_wr <= obs_wr + 1;
    end
  end

  logic [31:0] ft [8] = '{32'd85899, 32'd171799, 32'd429497, 32'd858993,
                          32'd1717987, 32'd4294967, 32'd8589935, 32'd17179869};

  int   n_cmp = 0, n_bad = 0, rd = 0;
  cfg_t exp_q[$];
  int   m_wave = 0, m_fidx = 0, m_phase = 0;
  bit   m_pend = 0, wrap_tied = 0;
  vec_t vt [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic cfg_t model_cfg();
    return '{f: ft[m_fidx], p: 12'(m_phase), w: 2'(m_wave)};
  endfunction

  task automatic model_reset();
    m_wave = 0; m_fidx = 0; m_phase = 0; m_pend = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_reset();
    rd = obs_wr;
  endtask

  task automatic press(input logic [2:0] m);
    if (m[0]) m_wave  = (m_wave + 1) % 4;
    if (m[1]) m_fidx  = (m_fidx + 1) % 8;
    if (m[2]) m_phase = (m_phase + 1024) % 4096;
    if (wrap_tied) exp_q.push_back(model_cfg());
    else           m_pend = 1;
    key0_in = ~m[0]; key1_in = ~m[1]; key2_in = ~m[2];
    tick(40);
    key0_in = 1'b1; key1_in = 1'b1; key2_in = 1'b1;
    tick(40);
  endtask

  task automatic pulse_wrap();
    acc_wrap = 1'b1;
    tick(1);
    acc_wrap = 1'b0;
    if (m_pend) exp_q.push_back(model_cfg());
    m_pend = 0;
  endtask

  task automatic drain();
    int   t;
    cfg_t e, o;
    t = 0;
    while ((obs_wr - rd) < exp_q.size() && t < 200) begin
      tick(1);
      t++;
    end
    tick(5);
    chk("cfg_valid_count", 32'(obs_wr - rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_wr) begin
        o = obs[rd % 256];
        chk("sb_freq",  o.f, e.f);
        chk("sb_phase", 32'(o.p), 32'(e.p));
        chk("sb_wave",  32'(o.w), 32'(e.w));
        rd++;
      end
    end
    rd = obs_wr;
  endtask

  initial begin
    bit pend_seen;

    vt[0] = '{mask: 3'b001, wave: 2'd1, freq: 32'd85899,  phase: 12'd0};
    vt[1] = '{mask: 3'b110, wave: 2'd1, freq: 32'd171799, phase: 12'd1024};
    vt[2] = '{mask: 3'b111, wave: 2'd2, freq: 32'd429497, phase: 12'd2048};
    vt[3] = '{mask: 3'b101, wave: 2'd3, freq: 32'd429497, phase: 12'd3072};
    vt[4] = '{mask: 3'b101, wave: 2'd0, freq: 32'd429497, phase: 12'd0};
    vt[5] = '{mask: 3'b010, wave: 2'd0, freq: 32'd858993, phase: 12'd0};

    // Reset state, idle with no keys.
    do_reset();
    chk("rst_freq",    freq_word, 32'd85899);
    chk("rst_phase",   32'(phase_word), 32'd0);
    chk("rst_wave",    32'(wave_sel), 32'd0);
    chk("rst_valid",   32'(cfg_valid), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    tick(50);
    drain();

    // Three frequency steps with acc_wrap tied high.
    wrap_tied = 1; acc_wrap = 1'b1;
    repeat (3) press(3'b010);
    drain();
    chk("freq_after_3", freq_word, 32'd858993);

    // Five phase steps: 1024, 2048, 3072, 0, 1024.
    repeat (5) press(3'b100);
    drain();
    chk("phase_after_5", 32'(phase_word), 32'd1024);
    acc_wrap = 1'b0; wrap_tied = 0;
    tick(2);

    // Async reset while a key1 press is pending.
    press(3'b010);
    chk("pend_before_rst", 32'(cfg_pending), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_freq",  freq_word, 32'd85899);
    chk("async_rst_phase", 32'(phase_word), 32'd0);
    chk("async_rst_pend",  32'(cfg_pending), 32'd0);
    tick(2);
    rst_n = 1'b1;
    model_reset();
    rd = obs_wr;
    tick(2);
    pulse_wrap();
    drain();
    chk("post_rst_freq", freq_word, 32'd85899);

    // key0 and key1 together, acc_wrap low for 500 cycles.
    do_reset();
    press(3'b011);
    tick(420);
    chk("hold_pending", 32'(cfg_pending), 32'd1);
    chk("hold_freq",    freq_word, 32'd85899);
    chk("hold_wave",    32'(wave_sel), 32'd0);
    chk("hold_no_valid", 32'(obs_wr - rd), 32'd0);
    pulse_wrap();
    drain();
    chk("joint_wave",    32'(wave_sel), 32'd1);
    chk("joint_freq",    freq_word, 32'd171799);
    chk("joint_pending", 32'(cfg_pending), 32'd0);

    // Bounce on key0: low 8, high 4, five times; must not register.
    pend_seen = 0;
    for (int i = 0; i < 5; i++) begin
      key0_in = 1'b0;
      for (int j = 0; j < 8; j++) begin tick(1); pend_seen |= cfg_pending; end
      key0_in = 1'b1;
      for (int j = 0; j < 4; j++) begin tick(1); pend_seen |= cfg_pending; end
    end
    for (int j = 0; j < 40; j++) begin tick(1); pend_seen |= cfg_pending; end
    chk("bounce_pending", 32'(pend_seen), 32'd0);
    pulse_wrap();
    drain();

    // Table-driven press / wrap vectors from reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(vt[i].mask);
      chk("vec_pending", 32'(cfg_pending), 32'd1);
      pulse_wrap();
      drain();
      chk("vec_wave",  32'(wave_sel), 32'(vt[i].wave));
      chk("vec_freq",  freq_word, vt[i].freq);
      chk("vec_phase", 32'(phase_word), 32'(vt[i].phase));
    end

    // Frequency index wraps 7 -> 0.
    wrap_tied = 1; acc_wrap = 1'b1;
    repeat (5) press(3'b010);
    drain();
    acc_wrap = 1'b0; wrap_tied = 0;
    chk("fidx_wrap_freq", freq_word, 32'd85899);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
